// File: rtl/universal_shift_reg.sv
// universal_shift_reg
//   Parameterised universal shift register with a frame counter.
//   Supports hold, shift left/right, rotate left/right and parallel load.
//   A counter tracks shifts since the last load/clear/wrap; after the
//   WIDTH-th shift it wraps to zero and frame_done pulses for one cycle.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   en         in   operation enable (0 = hold all state, frame_done low)
//   clr        in   synchronous clear, overrides en/mode
//   mode[2:0]  in   000 hold, 001 SL, 010 SR, 011 RL, 100 RR, 101 LD,
//                   110/111 hold
//   ser_in     in   serial input bit for SL/SR
//   par_in     in   parallel load data
//   q          out  register contents
//   ser_out    out  last bit shifted or rotated out (held on load/hold)
//   shift_cnt  out  shifts since last load, clear or frame wrap
//   frame_done out  one-cycle pulse following the WIDTH-th shift
module universal_shift_reg #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SL   = 3'b001;
  localparam logic [2:0] MODE_SR   = 3'b010;
  localparam logic [2:0] MODE_RL   = 3'b011;
  localparam logic [2:0] MODE_RR   = 3'b100;
  localparam logic [2:0] MODE_LD   = 3'b101;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] q_nxt;
  logic             ser_out_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             frame_done_nxt;
  logic             is_shift;

  always_comb begin
    q_nxt          = q;
    ser_out_nxt    = ser_out;
    cnt_nxt        = shift_cnt;
    frame_done_nxt = 1'b0;
    is_shift       = 1'b0;

    if (en) begin
      case (mode)
        MODE_SL: begin
          q_nxt       = {q[WIDTH-2:0], ser_in};
          ser_out_nxt = q[WIDTH-1];
          is_shift    = 1'b1;
        end
        MODE_SR: begin
          q_nxt       = {ser_in, q[WIDTH-1:1]};
          ser_out_nxt = q[0];
          is_shift    = 1'b1;
        end
        MODE_RL: begin
          q_nxt       = {q[WIDTH-2:0], q[WIDTH-1]};
          ser_out_nxt = q[WIDTH-1];
          is_shift    = 1'b1;
        end
        MODE_RR: begin
          q_nxt       = {q[0], q[WIDTH-1:1]};
          ser_out_nxt = q[0];
          is_shift    = 1'b1;
        end
        MODE_LD: begin
          q_nxt   = par_in;
          cnt_nxt = '0;
        end
        default: begin
          // MODE_HOLD and the two spare encodings: nothing changes.
        end
      endcase
    end

    // Any shift direction advances the same frame counter; the shift that
    // completes a frame wraps the count and raises frame_done.
    if (is_shift) begin
      if (shift_cnt == CNT_LAST) begin
        cnt_nxt        = '0;
        frame_done_nxt = 1'b1;
      end else begin
        cnt_nxt = shift_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q          <= '0;
      ser_out    <= 1'b0;
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else if (clr) begin
      q          <= '0;
      ser_out    <= 1'b0;
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      q          <= q_nxt;
      ser_out    <= ser_out_nxt;
      shift_cnt  <= cnt_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg
//   Directed scenarios plus a randomized run for universal_shift_reg
//   (WIDTH=8), checked against an integer-arithmetic reference model.
module tb_universal_shift_reg;

  localparam int W     = 8;
  localparam int CW    = $clog2(W + 1);
  localparam int MASK  = (1 << W) - 1;

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_SL   = 3'd1;
  localparam logic [2:0] M_SR   = 3'd2;
  localparam logic [2:0] M_RL   = 3'd3;
  localparam logic [2:0] M_RR   = 3'd4;
  localparam logic [2:0] M_LD   = 3'd5;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          clr;
  logic [2:0]    mode;
  logic          ser_in;
  logic [W-1:0]  par_in;
  logic [W-1:0]  q;
  logic          ser_out;
  logic [CW-1:0] shift_cnt;
  logic          frame_done;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .clr        (clr),
    .mode       (mode),
    .ser_in     (ser_in),
    .par_in     (par_in),
    .q          (q),
    .ser_out    (ser_out),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done)
  );

  int vectors;
  int miscompares;

  // ---------------- reference model ----------------
  // Register held as an integer; shifts are multiply/divide by two.
  int m_q, m_so, m_cnt, m_fd;

  task automatic model_reset();
    m_q = 0; m_so = 0; m_cnt = 0; m_fd = 0;
  endtask

  task automatic model_step();
    int msb, lsb, si;
    bit shifted;
    msb = m_q / (1 << (W - 1));
    lsb = m_q % 2;
    si  = int'(ser_in);
    shifted = 1'b0;
    if (clr) begin
      model_reset();
      return;
    end
    if (en) begin
      case (mode)
        M_SL: begin m_so = msb; m_q = (m_q * 2 + si) & MASK;            shifted = 1; end
        M_SR: begin m_so = lsb; m_q = m_q / 2 + si * (1 << (W - 1));    shifted = 1; end
        M_RL: begin m_so = msb; m_q = (m_q * 2 + msb) & MASK;           shifted = 1; end
        M_RR: begin m_so = lsb; m_q = m_q / 2 + lsb * (1 << (W - 1));   shifted = 1; end
        M_LD: begin m_q = int'(par_in); m_cnt = 0; end
        default: ;
      endcase
    end
    m_fd = 0;
    if (shifted) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == W) begin
        m_cnt = 0;
        m_fd  = 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic e, input logic c, input logic [2:0] m,
                        input logic s, input logic [W-1:0] p);
    en = e; clr = c; mode = m; ser_in = s; par_in = p;
  endtask

  // One clock edge: model follows the inputs sampled at the edge,
  // outputs are observed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    set_in(0, 0, M_HOLD, 0, '0);
    model_reset();
    #2;
    vectors++;
    if (q !== '0 || ser_out !== 1'b0 || shift_cnt !== '0 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: q=%h so=%b cnt=%0d fd=%b, required all zero", q, ser_out, shift_cnt, frame_done);
    end
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset = 1'b1;
    // First edge after release performs a load.
    set_in(1, 0, M_LD, 0, 8'h6B);
    tick();
    vectors++;
    if (q !== 8'h6B) begin
      miscompares++;
      $display("FAIL reset_release_load: q=%h required 6b", q);
    end
  endtask

  task automatic test_serial_out();
    logic [W-1:0] exp_bits;
    set_in(1, 0, M_LD, 0, 8'hA5);
    tick();
    exp_bits = 8'hA5;
    for (int i = 0; i < W; i++) begin
      set_in(1, 0, M_SL, 0, '0);
      tick();
      vectors++;
      if (ser_out !== exp_bits[W-1-i]) begin
        miscompares++;
        $display("FAIL serial_out_bit%0d: ser_out=%b required %b", i, ser_out, exp_bits[W-1-i]);
      end
      vectors++;
      if (frame_done !== (i == W - 1)) begin
        miscompares++;
        $display("FAIL serial_frame_done_%0d: fd=%b required %b", i, frame_done, (i == W - 1));
      end
    end
    vectors++;
    if (q !== 8'h00 || shift_cnt !== '0) begin
      miscompares++;
      $display("FAIL serial_final: q=%h cnt=%0d required 00/0", q, shift_cnt);
    end
    set_in(1, 0, M_HOLD, 0, '0);
    tick();
    vectors++;
    if (frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL serial_pulse_width: fd=%b required 0", frame_done);
    end
  endtask

  task automatic test_rotate();
    set_in(1, 0, M_LD, 0, 8'h81);
    tick();
    set_in(1, 0, M_RR, 0, '0);
    tick();
    vectors++;
    if (q !== 8'hC0 || ser_out !== 1'b1 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rotate_first: q=%h so=%b fd=%b required c0/1/0", q, ser_out, frame_done);
    end
    for (int i = 0; i < 7; i++) begin
      set_in(1, 0, M_RR, $urandom_range(0, 1), '0);
      tick();
    end
    vectors++;
    if (q !== 8'h81 || frame_done !== 1'b1 || shift_cnt !== '0) begin
      miscompares++;
      $display("FAIL rotate_frame: q=%h fd=%b cnt=%0d required 81/1/0", q, frame_done, shift_cnt);
    end
  endtask

  task automatic test_enable();
    set_in(1, 0, M_LD, 0, 8'h3C);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, M_SL, 1, 8'hFF);
      tick();
      vectors++;
      if (q !== 8'h3C || shift_cnt !== '0 || frame_done !== 1'b0) begin
        miscompares++;
        $display("FAIL enable_hold_%0d: q=%h cnt=%0d fd=%b required 3c/0/0", i, q, shift_cnt, frame_done);
      end
    end
  endtask

  task automatic test_priority();
    set_in(1, 1, M_LD, 0, 8'hFF);
    tick();
    vectors++;
    if (q !== 8'h00 || ser_out !== 1'b0 || shift_cnt !== '0) begin
      miscompares++;
      $display("FAIL clr_over_load: q=%h so=%b cnt=%0d required 00/0/0", q, ser_out, shift_cnt);
    end
    for (int i = 0; i < 7; i++) begin
      set_in(1, 0, M_SL, 1, '0);
      tick();
    end
    vectors++;
    if (shift_cnt !== CW'(7)) begin
      miscompares++;
      $display("FAIL seven_shifts_cnt: cnt=%0d required 7", shift_cnt);
    end
    set_in(1, 0, M_LD, 0, 8'h12);
    tick();
    vectors++;
    if (q !== 8'h12 || shift_cnt !== '0 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL load_resets_cnt: q=%h cnt=%0d fd=%b required 12/0/0", q, shift_cnt, frame_done);
    end
    for (int i = 0; i < W; i++) begin
      set_in(1, 0, M_SR, $urandom_range(0, 1), '0);
      tick();
      vectors++;
      if (frame_done !== (i == W - 1) || q !== W'(m_q)) begin
        miscompares++;
        $display("FAIL post_load_shift_%0d: q=%h fd=%b required %h/%b", i, q, frame_done, W'(m_q), (i == W - 1));
      end
    end
  endtask

  task automatic test_mixed();
    set_in(1, 0, M_LD, 0, 8'h01);
    tick();
    for (int i = 0; i < W; i++) begin
      set_in(1, 0, (i % 2 == 0) ? M_SL : M_SR, 1, '0);
      tick();
      vectors++;
      if (q !== W'(m_q) || ser_out !== m_so[0] || frame_done !== (i == W - 1)) begin
        miscompares++;
        $display("FAIL mixed_%0d: q=%h so=%b fd=%b required %h/%b/%b", i, q, ser_out, frame_done, W'(m_q), m_so[0], (i == W - 1));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    set_in(1, 0, M_LD, 0, 8'h2D);
    tick();
    set_in(1, 0, M_SL, 0, '0);
    tick();
    vectors++;
    if (q !== 8'h5A) begin
      miscompares++;
      $display("FAIL pre_reset_q: q=%h required 5a", q);
    end
    // Reset between edges while SL keeps being requested.
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (q !== 8'h00 || ser_out !== 1'b0 || shift_cnt !== '0) begin
      miscompares++;
      $display("FAIL async_reset: q=%h so=%b cnt=%0d required 00/0/0", q, ser_out, shift_cnt);
    end
    #1;
    reset = 1'b1;
    for (int i = 0; i < W; i++) begin
      set_in(1, 0, M_SL, 1, '0);
      tick();
      vectors++;
      if (frame_done !== (i == W - 1) || shift_cnt !== CW'(m_cnt)) begin
        miscompares++;
        $display("FAIL reset_discards_count_%0d: fd=%b cnt=%0d required %b/%0d", i, frame_done, shift_cnt, (i == W - 1), m_cnt);
      end
    end
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), W'($urandom));
      tick();
      vectors++;
      if (q !== W'(m_q) || ser_out !== m_so[0] || shift_cnt !== CW'(m_cnt) || frame_done !== m_fd[0]) begin
        miscompares++;
        $display("FAIL random_%0d: q=%h so=%b cnt=%0d fd=%b required %h/%b/%0d/%b",
                 i, q, ser_out, shift_cnt, frame_done, W'(m_q), m_so[0], m_cnt, m_fd[0]);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_serial_out();
    test_rotate();
    test_enable();
    test_priority();
    test_mixed();
    test_reset_mid_frame();
    test_back_to_back_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
